dvp_stream_receiver: RTL and testbench



---
 rtl/dvp_stream_receiver_if.sv | 12 +
 rtl/dvp_stream_receiver.sv | 244 ++++++++++++++++++++++++
 tb/tb_dvp_stream_receiver.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dvp_stream_receiver_if.sv
// Pixel stream leaving the DVP receiver: AXI-Stream style, no back-pressure.
interface dvp_stream_receiver_if #(
  parameter int unsigned TDATA_W = 16
);
  logic [TDATA_W-1:0] tdata;
  logic               tvalid;
  logic               tlast;
  logic               tuser;

  modport master (output tdata, tvalid, tlast, tuser);
  modport slave  (input  tdata, tvalid, tlast, tuser);
endinterface

// File: rtl/dvp_stream_receiver.sv
// DVP camera capture: packs BYTES_PER_PIXEL bus beats per pixel into a stream with tuser=SOF, tlast=EOL.
// Optional line/frame statistics outputs are enabled by defining DVP_STATS_EN.
module dvp_stream_receiver #(
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned BYTES_PER_PIXEL = 2,
  parameter bit          MSB_FIRST       = 1'b1,
  parameter bit          HREF_POL        = 1'b1,
  parameter bit          VSYNC_POL       = 1'b1,
  parameter int unsigned CNT_W           = 12
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     din,
  input  logic                  href,
  input  logic                  vsync,
  dvp_stream_receiver_if.master m_axis,
  output logic                  err_partial,
  output logic                  err_sync,
  output logic [15:0]           frame_cnt
`ifdef DVP_STATS_EN
  ,
  output logic [CNT_W-1:0]      line_width,
  output logic [CNT_W-1:0]      frame_height,
  output logic                  stats_valid
`endif
);

  localparam int unsigned BPP     = BYTES_PER_PIXEL;
  localparam int unsigned TDATA_W = DATA_W * BPP;
  localparam int unsigned IDX_W   = (BPP > 1) ? $clog2(BPP) : 1;

  if (BYTES_PER_PIXEL < 1 || BYTES_PER_PIXEL > 4) begin : g_bad_bpp
    $error("BYTES_PER_PIXEL must be in 1..4");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("CNT_W must be in 1..32");
  end

  typedef enum logic [1:0] {
    WAIT_VSYNC = 2'd0,
    BLANK      = 2'd1,
    ACTIVE     = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               byte_idx_q, byte_idx_d;
  logic [BPP-1:0][DATA_W-1:0]     acc_q, acc_d;
  logic [BPP-1:0][DATA_W-1:0]     pend_q, pend_d;
  logic [BPP-1:0][DATA_W-1:0]     word_new;
  logic                           pend_vld_q, pend_vld_d;
  logic                           sof_q, sof_d;
  logic                           seen_q, seen_d;
  logic                           vsync_act_q;

  logic [TDATA_W-1:0]             tdata_d;
  logic                           tvalid_d, tlast_d, tuser_d;
  logic                           err_partial_d, err_sync_d;
  logic [15:0]                    frame_cnt_d;

  logic                           href_act, vsync_act, vsync_edge;
  logic                           capture, word_done, line_end;
  logic [IDX_W-1:0]               slot;

`ifdef DVP_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0] line_width_d, frame_height_d;
  logic             stats_valid_d;
  logic             line_inc;
`endif

  assign href_act   = (href == HREF_POL);
  assign vsync_act  = (vsync == VSYNC_POL);
  assign vsync_edge = vsync_act && !vsync_act_q;

  // A beat is captured from BLANK as well so the first byte of a line is not lost.
  assign capture   = (state_q == BLANK || state_q == ACTIVE) && href_act && !vsync_act;
  assign word_done = capture && (byte_idx_q == IDX_W'(BPP - 1));
  assign line_end  = (state_q == ACTIVE) && (!href_act || vsync_act);
  assign slot      = MSB_FIRST ? (IDX_W'(BPP - 1) - byte_idx_q) : byte_idx_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    acc_d         = acc_q;
    pend_d        = pend_q;
    pend_vld_d    = pend_vld_q;
    sof_d         = sof_q;
    seen_d        = seen_q;
    tdata_d       = '0;
    tvalid_d      = 1'b0;
    tlast_d       = 1'b0;
    tuser_d       = 1'b0;
    err_partial_d = 1'b0;
    err_sync_d    = 1'b0;
    frame_cnt_d   = frame_cnt;
    word_new      = acc_q;
    word_new[slot] = din;

    if (capture) begin
      state_d = ACTIVE;
      if (word_done) begin
        byte_idx_d = '0;
        acc_d      = '0;
        pend_d     = word_new;
        pend_vld_d = 1'b1;
        if (pend_vld_q) begin
          tvalid_d = 1'b1;
          tdata_d  = TDATA_W'(pend_q);
        end
      end else begin
        byte_idx_d = byte_idx_q + IDX_W'(1);
        acc_d      = word_new;
      end
    end

    // End of line, either href falling or vsync aborting the line.
    if (line_end) begin
      state_d    = BLANK;
      byte_idx_d = '0;
      acc_d      = '0;
      pend_vld_d = 1'b0;
      if (pend_vld_q) begin
        tvalid_d = 1'b1;
        tlast_d  = 1'b1;
        tdata_d  = TDATA_W'(pend_q);
      end
      err_partial_d = (byte_idx_q != '0);
      err_sync_d    = href_act && vsync_act;
    end

    if (tvalid_d) begin
      tuser_d = sof_q;
      sof_d   = 1'b0;
    end

    if (vsync_act) begin
      state_d = BLANK;
      sof_d   = 1'b1;
    end

    // A frame only counts if it actually produced output.
    if (vsync_edge) begin
      if (seen_q || tvalid_d) begin
        frame_cnt_d = frame_cnt + 16'd1;
      end
      seen_d = 1'b0;
    end else if (tvalid_d) begin
      seen_d = 1'b1;
    end
  end

`ifdef DVP_STATS_EN
  // Saturating pixel/line counters sampled at line and frame boundaries.
  always_comb begin
    pix_cnt_d      = pix_cnt_q;
    line_cnt_d     = line_cnt_q;
    line_width_d   = line_width;
    frame_height_d = frame_height;
    stats_valid_d  = 1'b0;
    line_inc       = line_end && (pix_cnt_q != '0);

    if (word_done && pix_cnt_q != CNT_MAX) begin
      pix_cnt_d = pix_cnt_q + CNT_W'(1);
    end

    if (line_end) begin
      pix_cnt_d = '0;
      if (line_inc) begin
        line_width_d = pix_cnt_q;
        if (line_cnt_q != CNT_MAX) begin
          line_cnt_d = line_cnt_q + CNT_W'(1);
        end
      end
    end

    if (vsync_edge) begin
      if (seen_q || tvalid_d) begin
        stats_valid_d  = 1'b1;
        frame_height_d = (line_inc && line_cnt_q != CNT_MAX) ? line_cnt_q + CNT_W'(1)
                                                              : line_cnt_q;
      end
      line_cnt_d = '0;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      line_width   <= '0;
      frame_height <= '0;
      stats_valid  <= 1'b0;
    end else begin
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      line_width   <= line_width_d;
      frame_height <= frame_height_d;
      stats_valid  <= stats_valid_d;
    end
  end
`endif

  // State and output registers.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q       <= WAIT_VSYNC;
      byte_idx_q    <= '0;
      acc_q         <= '0;
      pend_q        <= '0;
      pend_vld_q    <= 1'b0;
      sof_q         <= 1'b0;
      seen_q        <= 1'b0;
      vsync_act_q   <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tlast  <= 1'b0;
      m_axis.tuser  <= 1'b0;
      err_partial   <= 1'b0;
      err_sync      <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      acc_q         <= acc_d;
      pend_q        <= pend_d;
      pend_vld_q    <= pend_vld_d;
      sof_q         <= sof_d;
      seen_q        <= seen_d;
      vsync_act_q   <= vsync_act;
      m_axis.tdata  <= tdata_d;
      m_axis.tvalid <= tvalid_d;
      m_axis.tlast  <= tlast_d;
      m_axis.tuser  <= tuser_d;
      err_partial   <= err_partial_d;
      err_sync      <= err_sync_d;
      frame_cnt     <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_dvp_stream_receiver.sv
// Bench for dvp_stream_receiver (BPP=2, MSB first): vector table, corner sequences, random frames vs model.
module tb_dvp_stream_receiver;
  localparam int unsigned DW  = 8;
  localparam int unsigned BPP = 2;
  localparam int unsigned TW  = DW * BPP;
  localparam int unsigned CW  = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          href;
  logic          vsync;
  logic          err_partial;
  logic          err_sync;
  logic [15:0]   frame_cnt;
`ifdef DVP_STATS_EN
  logic [CW-1:0] line_width;
  logic [CW-1:0] frame_height;
  logic          stats_valid;
`endif

  dvp_stream_receiver_if #(.TDATA_W(TW)) axis ();

  dvp_stream_receiver #(
    .DATA_W(DW), .BYTES_PER_PIXEL(BPP), .MSB_FIRST(1'b1),
    .HREF_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(CW)
  ) dut (
    .pclk(clk), .rst(rst), .din(din), .href(href), .vsync(vsync),
    .m_axis(axis), .err_partial(err_partial), .err_sync(err_sync),
    .frame_cnt(frame_cnt)
`ifdef DVP_STATS_EN
    , .line_width(line_width), .frame_height(frame_height), .stats_valid(stats_valid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TW-1:0] data;
    logic          last;
    logic          user;
  } beat_t;

  beat_t got_q[$];
  int    n_partial = 0;
  int    n_sync    = 0;
  int    n_stats   = 0;

  // Output monitor, sampled half a cycle after the active edge.
  always @(negedge clk) begin
    if (axis.tvalid) got_q.push_back('{data: axis.tdata, last: axis.tlast, user: axis.tuser});
    if (err_partial) n_partial++;
    if (err_sync) n_sync++;
`ifdef DVP_STATS_EN
    if (stats_valid) n_stats++;
`endif
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [DW-1:0] d, input logic h, input logic v);
    din = d; href = h; vsync = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc('0, 1'b0, 1'b0);
  endtask

  task automatic vpulse();
    cyc('0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b0);
  endtask

  task automatic drive_line(input int nb, input logic [7:0] start);
    for (int i = 0; i < nb; i++) cyc(DW'(int'(start) + i), 1'b1, 1'b0);
    cyc('0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc('0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  typedef struct {
    int            nbeats;
    logic [7:0]    start;
    int            exp_pix;
    int            exp_partial;
    logic [TW-1:0] exp_first;
    logic [TW-1:0] exp_last;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int    base, p0, s0, f0, st0;
    beat_t exp_q[$];
    int    exp_frames, exp_part;
    bit    sof, beats_since;

    rst = 1'b0; din = '0; href = 1'b0; vsync = 1'b0;
    do_reset();

    // Reset state
    chk("rst_tvalid", 32'(axis.tvalid), 32'd0);
    chk("rst_tdata", 32'(axis.tdata), 32'd0);
    chk("rst_tlast_tuser", 32'({axis.tlast, axis.tuser}), 32'd0);
    chk("rst_errs", 32'({err_partial, err_sync}), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);

    // Line-length table: beats in, pixel count / partial flag / first+last word out
    vecs[0] = '{10, 8'h00, 5, 0, 16'h0001, 16'h0809};
    vecs[1] = '{ 7, 8'h00, 3, 1, 16'h0001, 16'h0405};
    vecs[2] = '{ 1, 8'h40, 0, 1, 16'h0000, 16'h0000};
    vecs[3] = '{ 2, 8'hA0, 1, 0, 16'hA0A1, 16'hA0A1};
    vecs[4] = '{ 3, 8'hFE, 1, 1, 16'hFEFF, 16'hFEFF};
    vecs[5] = '{ 4, 8'h10, 2, 0, 16'h1011, 16'h1213};
    for (int v = 0; v < 6; v++) begin
      int nl;
      vpulse();
      base = got_q.size(); p0 = n_partial;
      drive_line(vecs[v].nbeats, vecs[v].start);
      idle(2);
      chk($sformatf("vec%0d_count", v), 32'(got_q.size() - base), 32'(vecs[v].exp_pix));
      chk($sformatf("vec%0d_partial", v), 32'(n_partial - p0), 32'(vecs[v].exp_partial));
      if (got_q.size() - base == vecs[v].exp_pix && vecs[v].exp_pix > 0) begin
        nl = 0;
        for (int i = base; i < got_q.size(); i++) nl += int'(got_q[i].last);
        chk($sformatf("vec%0d_first", v), 32'(got_q[base].data), 32'(vecs[v].exp_first));
        chk($sformatf("vec%0d_first_tuser", v), 32'(got_q[base].user), 32'd1);
        chk($sformatf("vec%0d_last", v), 32'(got_q[got_q.size()-1].data), 32'(vecs[v].exp_last));
        chk($sformatf("vec%0d_last_tlast", v), 32'(got_q[got_q.size()-1].last), 32'd1);
        chk($sformatf("vec%0d_tlast_count", v), 32'(nl), 32'd1);
      end
    end

    // No output before the first vsync; tuser only on the first line of a frame
    do_reset();
    base = got_q.size();
    drive_line(6, 8'h01);
    drive_line(5, 8'h11);
    idle(2);
    chk("novsync_no_beats", 32'(got_q.size() - base), 32'd0);
    vpulse();
    base = got_q.size();
    cyc(8'h20, 1'b1, 1'b0);
    cyc(8'h21, 1'b1, 1'b0);
    chk("lat_first_held", 32'(axis.tvalid), 32'd0);
    cyc(8'h22, 1'b1, 1'b0);
    cyc(8'h23, 1'b1, 1'b0);
    chk("lat_pending_valid", 32'(axis.tvalid), 32'd1);
    chk("lat_pending_data", 32'(axis.tdata), 32'h2021);
    cyc('0, 1'b0, 1'b0);
    chk("lat_eol_valid_last", 32'({axis.tvalid, axis.tlast}), 32'b11);
    chk("lat_eol_data", 32'(axis.tdata), 32'h2223);
    idle(1);
    drive_line(4, 8'h30);
    idle(2);
    chk("sof_count", 32'(got_q.size() - base), 32'd4);
    if (got_q.size() - base == 4) begin
      chk("sof_line1_tuser", 32'(got_q[base].user), 32'd1);
      chk("sof_line2_tuser", 32'(got_q[base+2].user), 32'd0);
      chk("sof_line2_data", 32'(got_q[base+2].data), 32'h3031);
    end

    // vsync rising while href is high aborts the line
    vpulse();
    f0 = int'(frame_cnt); s0 = n_sync; p0 = n_partial; base = got_q.size();
    for (int i = 0; i < 4; i++) cyc(DW'(8'h40 + i), 1'b1, 1'b0);
    cyc(8'h99, 1'b1, 1'b1);
    cyc('0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b0);
    idle(2);
    chk("abort_count", 32'(got_q.size() - base), 32'd2);
    if (got_q.size() - base == 2) begin
      chk("abort_beat0_last", 32'(got_q[base].last), 32'd0);
      chk("abort_beat1", 32'({got_q[base+1].data, got_q[base+1].last}), 32'({16'h4243, 1'b1}));
    end
    chk("abort_err_sync", 32'(n_sync - s0), 32'd1);
    chk("abort_err_partial", 32'(n_partial - p0), 32'd0);
    chk("abort_frame_cnt", 32'(frame_cnt), 32'(f0 + 1));
    // href during vsync in BLANK is ignored; an empty frame does not count
    base = got_q.size();
    cyc(8'h55, 1'b1, 1'b1);
    cyc(8'h56, 1'b1, 1'b1);
    cyc(8'h57, 1'b1, 1'b1);
    idle(3);
    chk("blank_vsync_href_beats", 32'(got_q.size() - base), 32'd0);
    chk("blank_vsync_href_err", 32'(n_sync - s0), 32'd1);
    chk("empty_frame_cnt", 32'(frame_cnt), 32'(f0 + 1));

    // Reset mid-line with a pixel pending
    vpulse();
    base = got_q.size();
    cyc(8'h60, 1'b1, 1'b0);
    cyc(8'h61, 1'b1, 1'b0);
    cyc(8'h62, 1'b1, 1'b0);
    rst = 1'b1;
    cyc(8'h63, 1'b1, 1'b0);
    rst = 1'b0;
    chk("midrst_outputs", 32'({axis.tvalid, axis.tlast, axis.tuser, err_partial, err_sync}), 32'd0);
    chk("midrst_tdata", 32'(axis.tdata), 32'd0);
    cyc(8'h64, 1'b1, 1'b0);
    cyc(8'h65, 1'b1, 1'b0);
    idle(2);
    drive_line(4, 8'h70);
    idle(2);
    chk("midrst_no_beats", 32'(got_q.size() - base), 32'd0);
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    vpulse();
    drive_line(2, 8'h50);
    idle(2);
    chk("resume_count", 32'(got_q.size() - base), 32'd1);
    if (got_q.size() - base == 1)
      chk("resume_beat", 32'(got_q[base]), 32'({16'h5051, 1'b1, 1'b1}));

`ifdef DVP_STATS_EN
    // 3 lines of 4 pixels
    do_reset();
    vpulse();
    st0 = n_stats;
    for (int l = 0; l < 3; l++) drive_line(8, 8'h80);
    idle(1);
    vpulse();
    idle(1);
    chk("stats_valid_pulses", 32'(n_stats - st0), 32'd1);
    chk("stats_line_width", 32'(line_width), 32'd4);
    chk("stats_frame_height", 32'(frame_height), 32'd3);
`else
    st0 = 0;
`endif

    // Random frames against a line-level reference model
    do_reset();
    base = got_q.size(); p0 = n_partial;
    exp_q = {}; exp_frames = 0; exp_part = 0; sof = 1'b0; beats_since = 1'b0;
    for (int g = 0; g < 2; g++) begin
      drive_line(int'($urandom_range(1, 9)), 8'($urandom));
      idle(1);
    end
    for (int f = 0; f < 7; f++) begin
      int nlines;
      repeat ($urandom_range(1, 3)) cyc('0, 1'b0, 1'b1);
      if (beats_since) exp_frames++;
      beats_since = 1'b0;
      sof = 1'b1;
      idle(int'($urandom_range(1, 3)));
      nlines = (f == 2) ? 0 : int'($urandom_range(1, 4));
      for (int l = 0; l < nlines; l++) begin
        logic [7:0] bytes[$];
        int nb, npix;
        nb = int'($urandom_range(1, 9));
        bytes = {};
        for (int i = 0; i < nb; i++) bytes.push_back(8'($urandom));
        foreach (bytes[i]) cyc(bytes[i], 1'b1, 1'b0);
        idle(int'($urandom_range(1, 3)));
        npix = nb / BPP;
        if (nb % BPP != 0) exp_part++;
        for (int p = 0; p < npix; p++) begin
          logic [TW-1:0] w;
          w = '0;
          for (int k = 0; k < BPP; k++) w |= TW'(bytes[p*BPP + k]) << ((BPP - 1 - k) * DW);
          exp_q.push_back('{data: w, last: (p == npix - 1), user: (sof && p == 0)});
        end
        if (npix > 0) begin
          sof = 1'b0;
          beats_since = 1'b1;
        end
      end
    end
    vpulse();
    if (beats_since) exp_frames++;
    idle(3);
    chk("rand_count", 32'(got_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++)
      chk($sformatf("rand_beat%0d", i), 32'(got_q[base+i]), 32'(exp_q[i]));
    chk("rand_partial", 32'(n_partial - p0), 32'(exp_part));
    chk("rand_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
